// File: rtl/sigma_decode_stage_if.sv
// sigma_decode_stage_if: fetch-side push and execute-side pop handshakes of the decode stage
interface sigma_decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
);
  logic                           flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [31:0]                    in_instr;
  logic [XLEN-1:0]                in_pc;
  logic                           out_valid;
  logic                           out_ready;
  logic [XLEN-1:0]                out_pc;
  logic [6:0]                     out_opcode;
  logic [4:0]                     out_rd;
  logic [2:0]                     out_funct3;
  logic [4:0]                     out_rs1;
  logic [4:0]                     out_rs2;
  logic [6:0]                     out_funct7;
  logic [XLEN-1:0]                out_imm;
  logic [2:0]                     out_fmt;
  logic                           out_illegal;
  logic [$clog2(QDEPTH+1)-1:0]    count;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
           out_funct7, out_imm, out_fmt, out_illegal, count
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
           out_funct7, out_imm, out_fmt, out_illegal, count
  );
endinterface

// File: rtl/sigma_decode_stage.sv
// sigma_decode_stage: RV32/RV64 base decode into a small FIFO; define SIGMA_DEC_M_EXT_EN to accept M-extension OP encodings
module sigma_decode_stage #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  sigma_decode_stage_if.slave io
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
`ifdef SIGMA_DEC_M_EXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_X = 3'd7;
  localparam logic [6:0] O_LOAD = 7'b0000011, O_MISC = 7'b0001111, O_OPIMM = 7'b0010011,
                         O_AUIPC = 7'b0010111, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                         O_LUI = 7'b0110111, O_BRANCH = 7'b1100011, O_JALR = 7'b1100111,
                         O_JAL = 7'b1101111, O_SYSTEM = 7'b1110011;
  logic [31:0]       ins;
  logic [6:0]        opc, f7, f7s;
  logic [2:0]        f3, base, fmt_d;
  logic              ill;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_d;
  assign ins = io.in_instr;
  always_comb begin
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    f7s   = (XLEN == 64) ? {f7[6:1], 1'b0} : f7;
    base  = (opc == O_OP) ? F_R :
            (opc == O_OPIMM || opc == O_LOAD || opc == O_JALR || opc == O_MISC || opc == O_SYSTEM) ? F_I :
            (opc == O_STORE) ? F_S :
            (opc == O_BRANCH) ? F_B :
            (opc == O_LUI || opc == O_AUIPC) ? F_U :
            (opc == O_JAL) ? F_J : F_X;
    ill   = (base == F_X)
         || (opc == O_JALR && f3 != 3'd0)
         || (opc == O_BRANCH && f3[2:1] == 2'b01)
         || (opc == O_LOAD && (f3 == 3'd7 || (XLEN == 32 && (f3 == 3'd3 || f3 == 3'd6))))
         || (opc == O_STORE && f3 > ((XLEN == 64) ? 3'd3 : 3'd2))
         || (opc == O_OP && !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))
                              || (MEXT && f7 == 7'd1)))
         || (opc == O_OPIMM && ((f3 == 3'd1 && f7s != 7'd0)
                             || (f3 == 3'd5 && f7s != 7'd0 && f7s != 7'b0100000)));
    fmt_d = ill ? F_X : base;
    imm32 = (fmt_d == F_I) ? {{20{ins[31]}}, ins[31:20]} :
            (fmt_d == F_S) ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
            (fmt_d == F_B) ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
            (fmt_d == F_U) ? {ins[31:12], 12'h000} :
            (fmt_d == F_J) ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : 32'sd0;
    imm_d = XLEN'(imm32);
  end
  logic [PW-1:0]   wp_q, rp_q, wp_d, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     ins_q [QDEPTH];
  logic [XLEN-1:0] pc_q  [QDEPTH];
  logic [XLEN-1:0] imm_q [QDEPTH];
  logic [2:0]      fmt_q [QDEPTH];
  logic            push, pop;
  assign io.in_ready  = cnt_q < CW'(QDEPTH);
  assign io.out_valid = cnt_q != '0;
  assign push  = io.in_valid && io.in_ready && !io.flush;
  assign pop   = io.out_valid && io.out_ready;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign wp_d  = wp_q + PW'(push);
  assign rp_d  = rp_q + PW'(pop);
  always_ff @(posedge clk) begin
    if (rst || io.flush) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end
  // storage is left unreset; the empty-queue mask below hides stale contents
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wp_q] <= ins;
      pc_q[wp_q]  <= io.in_pc;
      imm_q[wp_q] <= imm_d;
      fmt_q[wp_q] <= fmt_d;
    end
  end
  logic [31:0] hi;
  assign hi             = io.out_valid ? ins_q[rp_q] : '0;
  assign io.out_opcode  = hi[6:0];
  assign io.out_rd      = hi[11:7];
  assign io.out_funct3  = hi[14:12];
  assign io.out_rs1     = hi[19:15];
  assign io.out_rs2     = hi[24:20];
  assign io.out_funct7  = hi[31:25];
  assign io.out_pc      = io.out_valid ? pc_q[rp_q] : '0;
  assign io.out_imm     = io.out_valid ? imm_q[rp_q] : '0;
  assign io.out_fmt     = io.out_valid ? fmt_q[rp_q] : '0;
  assign io.out_illegal = io.out_valid && fmt_q[rp_q] == F_X;
  assign io.count       = cnt_q;
endmodule

// File: doc/sigma_decode_stage.md
SIGMA_DECODE_STAGE -- requirements
Module: sigma_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width for PC and immediates; legal values 32, 64.
REQ-002 Parameter QDEPTH, default 2, decoded-instruction queue depth; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discard all queued entries (branch or trap redirect).
REQ-006 in_valid  input  1  fetch presents an instruction.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 in_instr  input  32  raw RV32/RV64 base instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 out_valid  output  1  queue head holds a decoded instruction.
REQ-011 out_ready  input  1  execute consumes the queue head.
REQ-012 out_pc  output  XLEN  PC of the head entry.
REQ-013 out_opcode 7, out_rd 5, out_funct3 3, out_rs1 5, out_rs2 5, out_funct7 7  outputs  head fields, taken from bits 6:0, 11:7, 14:12, 19:15, 24:20, 31:25.
REQ-014 out_imm  output  XLEN  sign-extended immediate of the head entry.
REQ-015 out_fmt  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none/illegal.
REQ-016 out_illegal  output  1  head instruction is not a legal encoding.
REQ-017 count  output  $clog2(QDEPTH+1)  number of occupied queue entries.

Function
REQ-018 Decode is combinational on in_instr; the result and in_pc are written into the queue when in_valid and in_ready are both high.
REQ-019 in_ready is high exactly when count < QDEPTH, so the stage never accepts a push while full, even if the head is popped in the same cycle.
REQ-020 Latency: an instruction accepted in cycle N is visible on the out_* fields no earlier than cycle N+1, and there is no combinational in-to-out path.
REQ-021 out_valid is high exactly when count > 0; a pop occurs when out_valid and out_ready are both high.
REQ-022 A simultaneous push and pop leaves count unchanged, and the queue preserves FIFO order.
REQ-023 Read and write pointers wrap modulo QDEPTH.
REQ-024 While out_valid is low, all out_* data fields are 0.
REQ-025 flush empties the queue in the same cycle (count becomes 0 on the next edge) and takes priority over any push or pop in that cycle; an input presented in the flush cycle is dropped.
REQ-026 Immediates by format:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'h000}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All formats are sign-extended from the top bit to XLEN.
- R format and none: 0.
REQ-027 Format mapping:
- OP = R.
- OP-IMM, LOAD, JALR, MISC-MEM, SYSTEM = I.
- STORE = S; BRANCH = B; LUI, AUIPC = U; JAL = J.
REQ-028 An instruction is illegal (out_fmt=7, out_imm=0) if any of the following holds:
- instr[1:0] != 2'b11, or the opcode is not in the REQ-027 set;
- JALR with funct3 != 000;
- BRANCH with funct3 of 010 or 011;
- LOAD funct3 not in {000, 001, 010, 100, 101}, plus {011, 110} when XLEN=64;
- STORE funct3 above 010 (above 011 when XLEN=64);
- OP funct7 not 0000000, and not 0100000 with funct3 000 or 101;
- OP-IMM shift (funct3 001 or 101) with an invalid funct7 (the funct7[0] shamt bit is allowed when XLEN=64).
REQ-029 The register and funct fields are passed through unmodified even when the instruction is illegal.

Reset
REQ-030 When rst is high at a clock edge: count=0, both pointers=0, out_valid=0, and in_ready=1 from the next cycle.
REQ-031 Reset overrides flush, push and pop, and discards any entries in flight mid-operation.
REQ-032 Queue storage is not reset; REQ-024 masks the data outputs while the queue is empty.

Configuration
REQ-033 With macro SIGMA_DEC_M_EXT_EN defined, OP with funct7=0000001 (any funct3) is legal, format R.
REQ-034 Without SIGMA_DEC_M_EXT_EN, OP with funct7=0000001 is illegal per REQ-028.

Verification
REQ-035 Push 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_fmt=1, rd=1, rs1=2, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-036 Push 0xFE000EE3 (beq x0,x0,-4) -> out_fmt=3, out_imm=0xFFFFFFFC; push 0x000000B7 (lui x1,0) -> out_fmt=4, out_imm=0.
REQ-037 Push 0x022081B3 (mul x3,x1,x2) -> out_illegal=1, out_fmt=7 without the macro; out_illegal=0, out_fmt=0 with SIGMA_DEC_M_EXT_EN.
REQ-038 QDEPTH=2, out_ready=0, push 3 instructions back-to-back -> count=2 and in_ready=0 after the second push; raise out_ready -> the instructions drain in order, the third is accepted once count<2, and there is no loss or duplication.
REQ-039 With 2 entries queued, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, and the flushed input does not appear.
REQ-040 With the queue holding 1 entry, assert rst together with a push -> next cycle count=0, out_valid=0, in_ready=1, and all out_* fields are 0.
